// File: rtl/_nor_scheduler.sv
// Round-robin front end for one shared _nor reduction unit. It grants one
// requester at a time and holds that requester's operand on the unit for
// SETTLE_CYCLES cycles. It then captures the unit's result and strobes the
// result back to the owning requester.
module _nor_scheduler #(
   parameter int unsigned REQUESTERS    = 4,
   parameter int unsigned INPUT_WIDTH   = 8,
   parameter int unsigned SETTLE_CYCLES = 3
) (
   input  logic                                Clock,
   input  logic                                nReset,
   input  logic [REQUESTERS-1:0]               reqValid,
   output logic [REQUESTERS-1:0]               reqReady,
   input  logic [REQUESTERS*INPUT_WIDTH-1:0]   reqData,
   output logic [INPUT_WIDTH-1:0]              unitData,
   output logic                                unitEnable,
   input  logic                                unitResult,
   output logic [REQUESTERS-1:0]               respValid,
   output logic                                respData,
   output logic                                busy
);

   localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t                 state;
   state_t                 stateNext;
   logic [PW-1:0]          ptr;
   logic [PW-1:0]          owner;
   logic [CW-1:0]          cnt;

   logic [INPUT_WIDTH-1:0] reqWord [REQUESTERS];
   logic                   grantFound;
   logic [PW-1:0]          grantIdx;
   logic [PW-1:0]          grantIdxInc;
   int unsigned            scanIdx;
   logic                   transfer;

   // Unpack the flat operand bus into one word per requester
   always_comb begin
      for (int unsigned i = 0; i < REQUESTERS; i++) begin
         reqWord[i] = reqData[i*INPUT_WIDTH +: INPUT_WIDTH];
      end
   end

   // Rotating-priority scan: first valid requester at or after ptr wins
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      scanIdx    = 0;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         scanIdx = 32'(ptr) + k;
         if (scanIdx >= REQUESTERS) begin
            scanIdx = scanIdx - REQUESTERS;
         end
         if (!grantFound && reqValid[PW'(scanIdx)]) begin
            grantFound = 1'b1;
            grantIdx   = PW'(scanIdx);
         end
      end
      // explicit wrap so non-power-of-two requester counts stay in range
      if (grantIdx == PW'(REQUESTERS - 1)) begin
         grantIdxInc = '0;
      end else begin
         grantIdxInc = grantIdx + PW'(1);
      end
   end

   assign transfer = (state == IDLE) && grantFound;

   // State register
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state decision
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (grantFound) stateNext = SETTLE;
         SETTLE:  if (cnt == '0) stateNext = RESPOND;
         RESPOND: stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Transaction datapath: operand capture, ownership, settle count, result capture
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         ptr      <= '0;
         owner    <= '0;
         cnt      <= '0;
         unitData <= '0;
         respData <= 1'b0;
      end else begin
         if (transfer) begin
            unitData <= reqWord[grantIdx];
            owner    <= grantIdx;
            ptr      <= grantIdxInc;
            cnt      <= CW'(SETTLE_CYCLES - 1);
         end else if (state == SETTLE) begin
            if (cnt != '0) begin
               cnt <= cnt - CW'(1);
            end else begin
               respData <= unitResult;
            end
         end
      end
   end

   // Outputs decoded from state; grant only offered while idle
   always_comb begin
      unitEnable = (state == SETTLE);
      busy       = (state != IDLE);
      reqReady   = '0;
      respValid  = '0;
      for (int unsigned i = 0; i < REQUESTERS; i++) begin
         reqReady[i]  = transfer && (grantIdx == PW'(i));
         respValid[i] = (state == RESPOND) && (owner == PW'(i));
      end
   end

endmodule
